// File: rtl/debug_command_unit_pkg.sv
// rtl/debug_command_unit_pkg.sv - shared codes, field positions and state encodings for the debug command unit
package debug_command_unit_pkg;

    localparam int FRAME_W   = 32;
    localparam int PTR_W     = 9;

    localparam int CODE_MSB  = 31;
    localparam int CODE_LSB  = 26;
    localparam int VALID_BIT = 25;
    localparam int TYPE_MSB  = 24;
    localparam int TYPE_LSB  = 16;
    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 0;

    localparam logic [5:0] CMD_START      = 6'b000001;
    localparam logic [5:0] CMD_RESET      = 6'b000010;
    localparam logic [5:0] CMD_REQ_DATA   = 6'b000011;
    localparam logic [5:0] CMD_LOAD_LSB   = 6'b000100;
    localparam logic [5:0] CMD_LOAD_MSB   = 6'b000101;
    localparam logic [5:0] CMD_MODE_GET   = 6'b001000;
    localparam logic [5:0] CMD_MODE_CONT  = 6'b001001;
    localparam logic [5:0] CMD_MODE_STEP  = 6'b001010;
    localparam logic [5:0] CMD_STEP       = 6'b100000;

    localparam logic [8:0] REQ_IMEM       = 9'h001;
    localparam logic [8:0] REQ_DMEM       = 9'h002;
    localparam logic [8:0] REQ_REGFILE    = 9'h004;
    localparam logic [8:0] REQ_PC         = 9'h008;
    localparam logic [8:0] REQ_IF_ID      = 9'h010;
    localparam logic [8:0] REQ_ID_EX      = 9'h020;
    localparam logic [8:0] REQ_EX_MEM     = 9'h040;
    localparam logic [8:0] REQ_MEM_WB     = 9'h080;

    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESPOND  = 2'd1,
        ST_REQ_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_CONT = 1'b1
    } mode_t;

    function automatic logic [FRAME_W-1:0] ack_frame(input logic [5:0] code,
                                                     input logic ok,
                                                     input logic [PTR_W-1:0] ptr);
        return {code, ok, 9'b0, 7'b0, ptr};
    endfunction

endpackage

// File: rtl/debug_command_unit_frame_edge_detect.sv
// rtl/debug_command_unit_frame_edge_detect.sv - rising-edge detector on the frame valid bit with field split
module debug_command_unit_frame_edge_detect
    import debug_command_unit_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_CMD           = 6,
    parameter int NB_ADDR_TYPE     = 9,
    parameter int NB_ADDR_DATA     = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    output logic                        o_accept,
    output logic [NB_CMD-1:0]           o_code,
    output logic [NB_ADDR_TYPE-1:0]     o_addr_type,
    output logic [NB_ADDR_DATA-1:0]     o_address
);

    logic valid_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_d <= 1'b0;
        end else if (i_valid) begin
            valid_d <= i_frame[VALID_BIT];
        end
    end

    // A level held high fires once; the edge is qualified by the clock enable.
    assign o_accept    = i_valid & i_frame[VALID_BIT] & ~valid_d;
    assign o_code      = i_frame[CODE_MSB:CODE_LSB];
    assign o_addr_type = i_frame[TYPE_MSB:TYPE_LSB];
    assign o_address   = i_frame[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/debug_command_unit.sv
// rtl/debug_command_unit.sv - MicroBlaze command frame responder sequencing the MIPS pipeline and debug reads
module debug_command_unit
    import debug_command_unit_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_INSTR         = 32,
    parameter int NB_INSTR_ADDR    = 9,
    parameter int NB_ADDR_DATA     = 16,
    parameter int NB_CMD           = 6,
    parameter int NB_ADDR_TYPE     = 9,
    parameter int REQ_TIMEOUT      = 15
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
    output logic                        o_frame_valid,
    output logic                        o_pipe_reset,
    output logic                        o_pipe_enable,
    input  logic                        i_pipe_halt,
    output logic                        o_imem_we,
    output logic [NB_INSTR_ADDR-1:0]    o_imem_addr,
    output logic [NB_INSTR-1:0]         o_imem_data,
    output logic                        o_req_valid,
    output logic [NB_ADDR_TYPE-1:0]     o_req_type,
    output logic [NB_ADDR_DATA-1:0]     o_req_addr,
    input  logic                        i_req_data_valid,
    input  logic [NB_CONTROL_FRAME-1:0] i_req_data
);

    localparam int NB_WAIT = $clog2(REQ_TIMEOUT + 1);

    logic                     accept;
    logic [NB_CMD-1:0]        code;
    logic [NB_ADDR_TYPE-1:0]  addr_type;
    logic [NB_ADDR_DATA-1:0]  address;

    state_t                   state, state_next;
    mode_t                    mode, mode_n;
    logic                     running, running_n;
    logic [NB_INSTR_ADDR-1:0] wr_ptr, wr_ptr_n;
    logic                     lsb_loaded, lsb_loaded_n;
    logic [NB_ADDR_DATA-1:0]  lsb, lsb_n;
    logic [NB_WAIT-1:0]       wait_cnt;
    logic                     step_q;
    logic                     timeout;
    logic                     cmd_take;

    logic                        resp_fire;
    logic [NB_CONTROL_FRAME-1:0] resp_frame;
    logic                        pipe_reset_n, step_n, imem_we_n, req_n;

    debug_command_unit_frame_edge_detect #(
        .NB_CONTROL_FRAME (NB_CONTROL_FRAME),
        .NB_CMD           (NB_CMD),
        .NB_ADDR_TYPE     (NB_ADDR_TYPE),
        .NB_ADDR_DATA     (NB_ADDR_DATA)
    ) u_edge (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_frame     (i_frame_from_blaze),
        .o_accept    (accept),
        .o_code      (code),
        .o_addr_type (addr_type),
        .o_address   (address)
    );

    assign cmd_take = accept && (state == ST_IDLE);
    assign timeout  = (wait_cnt == NB_WAIT'(REQ_TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else if (i_valid) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_take) begin
                    state_next = (code == CMD_REQ_DATA) ? ST_REQ_WAIT : ST_RESPOND;
                end
            end
            ST_RESPOND:  state_next = ST_IDLE;
            ST_REQ_WAIT: begin
                if (i_req_data_valid || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running_n    = running;
        mode_n       = mode;
        wr_ptr_n     = wr_ptr;
        lsb_loaded_n = lsb_loaded;
        lsb_n        = lsb;
        resp_fire    = 1'b0;
        resp_frame   = '0;
        pipe_reset_n = 1'b0;
        step_n       = 1'b0;
        imem_we_n    = 1'b0;
        req_n        = 1'b0;
        if (cmd_take) begin
            resp_fire  = 1'b1;
            resp_frame = ack_frame(code, 1'b0, wr_ptr);
            case (code)
                CMD_RESET: begin
                    pipe_reset_n = 1'b1;
                    running_n    = 1'b0;
                    wr_ptr_n     = '0;
                    lsb_loaded_n = 1'b0;
                    resp_frame   = ack_frame(code, 1'b1, '0);
                end
                CMD_START: begin
                    running_n  = 1'b1;
                    resp_frame = ack_frame(code, 1'b1, wr_ptr);
                end
                CMD_STEP: begin
                    // A halt arriving together with the step wins.
                    if (running && mode == MODE_STEP && !i_pipe_halt) begin
                        step_n     = 1'b1;
                        resp_frame = ack_frame(code, 1'b1, wr_ptr);
                    end
                end
                CMD_MODE_CONT: begin
                    mode_n     = MODE_CONT;
                    resp_frame = ack_frame(code, 1'b1, wr_ptr);
                end
                CMD_MODE_STEP: begin
                    mode_n     = MODE_STEP;
                    resp_frame = ack_frame(code, 1'b1, wr_ptr);
                end
                CMD_MODE_GET: begin
                    resp_frame = {code, 1'b1, 24'b0, logic'(mode)};
                end
                CMD_LOAD_LSB: begin
                    if (!running) begin
                        lsb_n        = address;
                        lsb_loaded_n = 1'b1;
                        resp_frame   = ack_frame(code, 1'b1, wr_ptr);
                    end
                end
                CMD_LOAD_MSB: begin
                    if (!running && lsb_loaded) begin
                        imem_we_n    = 1'b1;
                        wr_ptr_n     = wr_ptr + 1'b1;
                        lsb_loaded_n = 1'b0;
                        resp_frame   = ack_frame(code, 1'b1, wr_ptr + 1'b1);
                    end
                end
                CMD_REQ_DATA: begin
                    resp_fire = 1'b0;
                    req_n     = 1'b1;
                end
                default: ;
            endcase
        end else if (state == ST_REQ_WAIT) begin
            if (i_req_data_valid) begin
                resp_fire  = 1'b1;
                resp_frame = i_req_data;
            end else if (timeout) begin
                resp_fire  = 1'b1;
                resp_frame = TIMEOUT_SENTINEL;
            end
        end
        if (i_pipe_halt) begin
            running_n = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mode             <= MODE_STEP;
            running          <= 1'b0;
            wr_ptr           <= '0;
            lsb_loaded       <= 1'b0;
            lsb              <= '0;
            wait_cnt         <= '0;
            step_q           <= 1'b0;
            o_frame_to_blaze <= '0;
            o_frame_valid    <= 1'b0;
            o_pipe_reset     <= 1'b0;
            o_imem_we        <= 1'b0;
            o_imem_addr      <= '0;
            o_imem_data      <= '0;
            o_req_valid      <= 1'b0;
            o_req_type       <= '0;
            o_req_addr       <= '0;
        end else if (i_valid) begin
            mode          <= mode_n;
            running       <= running_n;
            wr_ptr        <= wr_ptr_n;
            lsb_loaded    <= lsb_loaded_n;
            lsb           <= lsb_n;
            step_q        <= step_n;
            o_frame_valid <= resp_fire;
            o_pipe_reset  <= pipe_reset_n;
            o_imem_we     <= imem_we_n;
            o_req_valid   <= req_n;
            wait_cnt      <= (state == ST_REQ_WAIT) ? wait_cnt + 1'b1 : '0;
            if (resp_fire) begin
                o_frame_to_blaze <= resp_frame;
            end
            if (imem_we_n) begin
                o_imem_addr <= wr_ptr;
                o_imem_data <= {address, lsb};
            end
            if (req_n) begin
                o_req_type <= addr_type;
                o_req_addr <= address;
            end
        end
    end

    assign o_pipe_enable = (running && mode == MODE_CONT) || step_q;

endmodule

// File: tb/tb_debug_command_unit.sv
// tb/tb_debug_command_unit.sv - directed self-checking bench for debug_command_unit
module tb_debug_command_unit;
    import debug_command_unit_pkg::*;

    logic        tb_clock_i = 1'b0;
    logic        reset;
    logic        valid_en;
    logic [31:0] frame;
    logic [31:0] frame_out;
    logic        frame_valid;
    logic        pipe_reset;
    logic        pipe_enable;
    logic        pipe_halt;
    logic        imem_we;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic        req_valid;
    logic [8:0]  req_type;
    logic [15:0] req_addr;
    logic        req_data_valid;
    logic [31:0] req_data;

    int n_checks = 0;
    int n_pass   = 0;
    int resp_cnt = 0;
    int rst_cnt  = 0;
    int en_cnt   = 0;
    int we_cnt   = 0;
    logic [31:0] last_resp  = '0;
    logic [8:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    debug_command_unit dut (
        .i_clock            (tb_clock_i),
        .i_reset            (reset),
        .i_valid            (valid_en),
        .i_frame_from_blaze (frame),
        .o_frame_to_blaze   (frame_out),
        .o_frame_valid      (frame_valid),
        .o_pipe_reset       (pipe_reset),
        .o_pipe_enable      (pipe_enable),
        .i_pipe_halt        (pipe_halt),
        .o_imem_we          (imem_we),
        .o_imem_addr        (imem_addr),
        .o_imem_data        (imem_data),
        .o_req_valid        (req_valid),
        .o_req_type         (req_type),
        .o_req_addr         (req_addr),
        .i_req_data_valid   (req_data_valid),
        .i_req_data         (req_data)
    );

    always #5 tb_clock_i = ~tb_clock_i;

    always @(posedge tb_clock_i) begin
        #1;
        if (frame_valid) begin
            resp_cnt++;
            last_resp = frame_out;
        end
        if (pipe_reset)  rst_cnt++;
        if (pipe_enable) en_cnt++;
        if (imem_we) begin
            we_cnt++;
            last_waddr = imem_addr;
            last_wdata = imem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_counts();
        resp_cnt = 0;
        rst_cnt  = 0;
        en_cnt   = 0;
        we_cnt   = 0;
    endtask

    task automatic send_cmd(input logic [5:0] code, input logic [8:0] atype,
                            input logic [15:0] addr, input int hold);
        frame = {code, 1'b1, atype, addr};
        repeat (hold) @(negedge tb_clock_i);
        frame[25] = 1'b0;
        repeat (3) @(negedge tb_clock_i);
    endtask

    task automatic halt_pulse();
        pipe_halt = 1'b1;
        @(negedge tb_clock_i);
        pipe_halt = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int waited);
        waited = 0;
        while (!frame_valid && waited < limit) begin
            @(negedge tb_clock_i);
            waited++;
        end
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        valid_en       = 1'b1;
        frame          = '0;
        pipe_halt      = 1'b0;
        req_data_valid = 1'b0;
        req_data       = '0;
        repeat (3) @(negedge tb_clock_i);
        reset = 1'b0;
        check("reset_frame", frame_out, 32'h0);
        check("reset_flags", {26'b0, frame_valid, pipe_reset, pipe_enable, imem_we, req_valid, 1'b0}, 32'h0);

        clear_counts();
        send_cmd(CMD_RESET, 9'h0, 16'h0, 3);
        check("reset_cmd_pulses", rst_cnt, 1);
        check("reset_cmd_resps", resp_cnt, 1);
        check("reset_cmd_ack", last_resp, 32'h0A00_0000);

        send_cmd(CMD_MODE_CONT, 9'h0, 16'h0, 1);
        check("mode_cont_ack", last_resp, 32'h2600_0000);
        send_cmd(CMD_START, 9'h0, 16'h0, 1);
        check("start_ack", last_resp, 32'h0600_0000);
        check("cont_enable", pipe_enable, 1);
        repeat (5) @(negedge tb_clock_i);
        check("cont_enable_hold", pipe_enable, 1);
        halt_pulse();
        check("halt_enable", pipe_enable, 0);

        send_cmd(CMD_MODE_STEP, 9'h0, 16'h0, 1);
        check("mode_step_ack", last_resp, 32'h2A00_0000);
        send_cmd(CMD_MODE_GET, 9'h0, 16'h0, 1);
        check("mode_get", last_resp, 32'h2200_0000);
        send_cmd(CMD_STEP, 9'h0, 16'h0, 1);
        check("step_nak", last_resp, 32'h8000_0000);
        send_cmd(CMD_START, 9'h0, 16'h0, 1);
        check("step_mode_idle_en", pipe_enable, 0);
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            send_cmd(CMD_STEP, 9'h0, 16'h0, 1);
            check("step_ack", last_resp, 32'h8200_0000);
        end
        check("step_pulses", en_cnt, 3);
        halt_pulse();

        clear_counts();
        send_cmd(CMD_LOAD_LSB, 9'h0, 16'h0F00, 1);
        check("lsb_ack", last_resp, 32'h1200_0000);
        send_cmd(CMD_LOAD_MSB, 9'h0, 16'h0FFF, 1);
        check("msb_ack", last_resp, 32'h1600_0001);
        check("imem_we_cnt", we_cnt, 1);
        check("imem_addr", last_waddr, 32'h0);
        check("imem_data", last_wdata, 32'h0FFF_0F00);
        clear_counts();
        send_cmd(CMD_LOAD_MSB, 9'h0, 16'h1234, 1);
        check("msb_nolsb_nak", last_resp, 32'h1400_0001);
        check("msb_nolsb_nowrite", we_cnt, 0);
        for (int i = 1; i < 512; i++) begin
            send_cmd(CMD_LOAD_LSB, 9'h0, 16'(i), 1);
            send_cmd(CMD_LOAD_MSB, 9'h0, 16'hA000, 1);
        end
        check("wrap_writes", we_cnt, 511);
        check("wrap_last_addr", last_waddr, 32'h1FF);
        check("wrap_last_data", last_wdata, 32'hA000_01FF);
        check("wrap_ack", last_resp, 32'h1600_0000);

        send_cmd(CMD_START, 9'h0, 16'h0, 1);
        send_cmd(CMD_LOAD_LSB, 9'h0, 16'h5555, 1);
        check("lsb_running_nak", last_resp, 32'h1000_0000);
        send_cmd(6'h3F, 9'h0, 16'h0, 1);
        check("unknown_nak", last_resp, 32'hFC00_0000);
        halt_pulse();

        clear_counts();
        frame = {CMD_REQ_DATA, 1'b1, REQ_DMEM, 16'h0001};
        @(negedge tb_clock_i);
        check("req_fields", {req_valid, req_type, req_addr}, {6'b0, 1'b1, 9'h002, 16'h0001});
        frame[25] = 1'b0;
        repeat (3) @(negedge tb_clock_i);
        req_data_valid = 1'b1;
        req_data       = 32'h1234_5678;
        @(negedge tb_clock_i);
        req_data_valid = 1'b0;
        repeat (20) @(negedge tb_clock_i);
        check("req_data_resps", resp_cnt, 1);
        check("req_data_resp", last_resp, 32'h1234_5678);

        clear_counts();
        frame = {CMD_REQ_DATA, 1'b1, REQ_DMEM, 16'h0001};
        @(negedge tb_clock_i);
        frame[25] = 1'b0;
        wait_resp(40, n);
        check("timeout_cycles", n, 15);
        check("timeout_resp", frame_out, 32'hDEAD_BEEF);

        clear_counts();
        frame = {CMD_REQ_DATA, 1'b1, REQ_DMEM, 16'h0001};
        @(negedge tb_clock_i);
        frame[25] = 1'b0;
        repeat (2) @(negedge tb_clock_i);
        frame = {CMD_RESET, 1'b1, 9'h0, 16'h0};
        repeat (2) @(negedge tb_clock_i);
        frame[25] = 1'b0;
        wait_resp(40, n);
        repeat (5) @(negedge tb_clock_i);
        check("wait_drop_rst", rst_cnt, 0);
        check("wait_drop_resps", resp_cnt, 1);
        check("wait_drop_resp", last_resp, 32'hDEAD_BEEF);

        clear_counts();
        frame = {CMD_REQ_DATA, 1'b1, REQ_DMEM, 16'h0001};
        @(negedge tb_clock_i);
        frame[25] = 1'b0;
        repeat (3) @(negedge tb_clock_i);
        reset = 1'b1;
        @(negedge tb_clock_i);
        reset = 1'b0;
        req_data_valid = 1'b1;
        @(negedge tb_clock_i);
        req_data_valid = 1'b0;
        repeat (20) @(negedge tb_clock_i);
        check("midreset_resps", resp_cnt, 0);
        check("midreset_frame", frame_out, 32'h0);
        check("midreset_flags", {26'b0, frame_valid, pipe_reset, pipe_enable, imem_we, req_valid, 1'b0}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
